// File: rtl/pdp8_pkg.sv
// Shared PDP-8 decode types, op7 code table, scoreboard state/rule indices and
// the fetch-word-to-decode predictor used by the IFD scoreboard.
package pdp8_pkg;

    typedef struct packed {
        logic        op_and;
        logic        op_tad;
        logic        op_isz;
        logic        op_dca;
        logic        op_jms;
        logic        op_jmp;
        logic [11:0] mem_inst_addr;
    } pdp_mem_opcode_s;

    // Field order is also the coverage bin order (nop = bin 0 ... cla2 = bin 21).
    typedef struct packed {
        logic nop;
        logic iac;
        logic ral;
        logic rtl;
        logic rar;
        logic rtr;
        logic cml;
        logic cma;
        logic cia;
        logic cll;
        logic cla_cll;
        logic cla1;
        logic hlt;
        logic osr;
        logic skp;
        logic snl;
        logic szl;
        logic sza;
        logic sna;
        logic sma;
        logic spa;
        logic cla2;
    } pdp_op7_opcode_s;

    typedef struct packed {
        pdp_mem_opcode_s mem;
        pdp_op7_opcode_s op7;
    } ifd_pred_s;

    localparam int PRED_W = $bits(ifd_pred_s);
    localparam int NUM_BINS = 28;

    localparam logic [2:0] MEM_AND = 3'd0;
    localparam logic [2:0] MEM_TAD = 3'd1;
    localparam logic [2:0] MEM_ISZ = 3'd2;
    localparam logic [2:0] MEM_DCA = 3'd3;
    localparam logic [2:0] MEM_JMS = 3'd4;
    localparam logic [2:0] MEM_JMP = 3'd5;
    localparam logic [2:0] OPC_OP7 = 3'd7;

    localparam logic [11:0] OP7_NOP     = 12'o7000;
    localparam logic [11:0] OP7_IAC     = 12'o7001;
    localparam logic [11:0] OP7_RAL     = 12'o7004;
    localparam logic [11:0] OP7_RTL     = 12'o7006;
    localparam logic [11:0] OP7_RAR     = 12'o7010;
    localparam logic [11:0] OP7_RTR     = 12'o7012;
    localparam logic [11:0] OP7_CML     = 12'o7020;
    localparam logic [11:0] OP7_CMA     = 12'o7040;
    localparam logic [11:0] OP7_CIA     = 12'o7041;
    localparam logic [11:0] OP7_CLL     = 12'o7100;
    localparam logic [11:0] OP7_CLA_CLL = 12'o7300;
    localparam logic [11:0] OP7_CLA1    = 12'o7200;
    localparam logic [11:0] OP7_HLT     = 12'o7402;
    localparam logic [11:0] OP7_OSR     = 12'o7404;
    localparam logic [11:0] OP7_SKP     = 12'o7410;
    localparam logic [11:0] OP7_SNL     = 12'o7420;
    localparam logic [11:0] OP7_SZL     = 12'o7430;
    localparam logic [11:0] OP7_SZA     = 12'o7440;
    localparam logic [11:0] OP7_SNA     = 12'o7450;
    localparam logic [11:0] OP7_SMA     = 12'o7500;
    localparam logic [11:0] OP7_SPA     = 12'o7510;
    localparam logic [11:0] OP7_CLA2    = 12'o7600;

    typedef enum logic [1:0] {
        SB_WAIT_FIRST = 2'd0,
        SB_RUN        = 2'd1,
        SB_HALTED     = 2'd2
    } ifd_sb_state_e;

    localparam int RULE_MULTI     = 0;
    localparam int RULE_MISMATCH  = 1;
    localparam int RULE_FETCH_OPC = 2;
    localparam int RULE_START     = 3;
    localparam int RULE_PC        = 4;
    localparam int RULE_OVERFLOW  = 5;
    localparam int RULE_EMPTY     = 6;
    localparam int RULE_HALTED    = 7;

    // IOT words (opcode 6) predict an all-zero decode.
    function automatic ifd_pred_s predict_decode(input logic [11:0] word);
        ifd_pred_s p;
        p = '0;
        if (word[11:9] <= MEM_JMP) begin
            p.mem.mem_inst_addr = {3'b000, word[8:0]};
        end
        case (word[11:9])
            MEM_AND: p.mem.op_and = 1'b1;
            MEM_TAD: p.mem.op_tad = 1'b1;
            MEM_ISZ: p.mem.op_isz = 1'b1;
            MEM_DCA: p.mem.op_dca = 1'b1;
            MEM_JMS: p.mem.op_jms = 1'b1;
            MEM_JMP: p.mem.op_jmp = 1'b1;
            OPC_OP7: begin
                case (word)
                    OP7_IAC:     p.op7.iac     = 1'b1;
                    OP7_RAL:     p.op7.ral     = 1'b1;
                    OP7_RTL:     p.op7.rtl     = 1'b1;
                    OP7_RAR:     p.op7.rar     = 1'b1;
                    OP7_RTR:     p.op7.rtr     = 1'b1;
                    OP7_CML:     p.op7.cml     = 1'b1;
                    OP7_CMA:     p.op7.cma     = 1'b1;
                    OP7_CIA:     p.op7.cia     = 1'b1;
                    OP7_CLL:     p.op7.cll     = 1'b1;
                    OP7_CLA_CLL: p.op7.cla_cll = 1'b1;
                    OP7_CLA1:    p.op7.cla1    = 1'b1;
                    OP7_HLT:     p.op7.hlt     = 1'b1;
                    OP7_OSR:     p.op7.osr     = 1'b1;
                    OP7_SKP:     p.op7.skp     = 1'b1;
                    OP7_SNL:     p.op7.snl     = 1'b1;
                    OP7_SZL:     p.op7.szl     = 1'b1;
                    OP7_SZA:     p.op7.sza     = 1'b1;
                    OP7_SNA:     p.op7.sna     = 1'b1;
                    OP7_SMA:     p.op7.sma     = 1'b1;
                    OP7_SPA:     p.op7.spa     = 1'b1;
                    OP7_CLA2:    p.op7.cla2    = 1'b1;
                    default:     p.op7.nop     = 1'b1;
                endcase
            end
            default: ;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/ifd_sb_fifo.sv
// Outstanding-fetch queue of predicted decodes. A pop and a push in the same
// cycle are both honoured even when full; pops on empty and pushes on full are dropped.
module ifd_sb_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 40,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     dout,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0] CNT_ONE = (PTR_W + 1)'(1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ifd_scoreboard.sv
// Passive IFD fetch/decode scoreboard: predicts each decode from the fetched word
// and flags rule violations. Define IFD_SB_COV_EN to build the per-opcode coverage bins.
module ifd_scoreboard
    import pdp8_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 12,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16,
    parameter logic [ADDR_W-1:0] START_ADDR = 'o200
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ifu_rd_req,
    input  logic [ADDR_W-1:0] ifu_rd_addr,
    input  logic [DATA_W-1:0] ifu_rd_data,
    input  logic [ADDR_W-1:0] base_addr,
    input  pdp_mem_opcode_s   pdp_mem_opcode,
    input  pdp_op7_opcode_s   pdp_op7_opcode,
    input  logic              stall,
    input  logic [ADDR_W-1:0] PC_value,
    output logic [7:0]        err_sticky,
    output logic              err_pulse,
    output logic [2:0]        err_rule,
    output logic [CNT_W-1:0]  chk_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    input  logic [4:0]        cov_sel,
    output logic [CNT_W-1:0]  cov_cnt,
    output logic [1:0]        sb_state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [7:0] DECODE_RULES = 8'b0100_1011;

    ifd_sb_state_e     state_q, state_d;
    logic              prev_req, prev_stall, fetch_pend;
    logic              fetch, decode, multi;
    logic [NUM_BINS-1:0] flags;
    logic [PRED_W-1:0] obs, head, pred_in;
    logic              full, empty;
    logic [PTR_W:0]    unused_count;
    logic [7:0]        fail;
    logic [2:0]        low_rule;

    assign obs     = {pdp_mem_opcode, pdp_op7_opcode};
    assign pred_in = predict_decode(ifu_rd_data[DATA_W-1 -: 12]);
    assign sb_state = state_q;

    always_comb begin
        flags = '0;
        for (int i = 0; i < 22; i++) flags[i] = pdp_op7_opcode[21-i];
        flags[22] = pdp_mem_opcode.op_and;
        flags[23] = pdp_mem_opcode.op_tad;
        flags[24] = pdp_mem_opcode.op_isz;
        flags[25] = pdp_mem_opcode.op_dca;
        flags[26] = pdp_mem_opcode.op_jms;
        flags[27] = pdp_mem_opcode.op_jmp;
    end

    assign multi  = |(flags & (flags - NUM_BINS'(1)));
    assign fetch  = ifu_rd_req & ~prev_req;
    assign decode = (|flags) & stall & ~prev_stall;

    // The fetch word arrives the cycle after the request edge; the prediction is
    // pushed then, so an entry becomes poppable once its data has been captured.
    ifd_sb_fifo #(.DEPTH(DEPTH), .W(PRED_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fetch_pend),
        .pop   (decode),
        .din   (pred_in),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (unused_count)
    );

    always_comb begin
        fail = '0;
        fail[RULE_MULTI]     = decode & multi;
        fail[RULE_MISMATCH]  = decode & ~empty & (obs != head);
        fail[RULE_FETCH_OPC] = fetch & (obs != '0);
        fail[RULE_START]     = decode & (state_q == SB_WAIT_FIRST) & (base_addr != START_ADDR);
        fail[RULE_PC]        = fetch & (state_q == SB_RUN) & (ifu_rd_addr != PC_value);
        fail[RULE_OVERFLOW]  = fetch_pend & full & ~decode;
        fail[RULE_EMPTY]     = decode & empty;
        fail[RULE_HALTED]    = fetch & (state_q == SB_HALTED);
    end

    always_comb begin
        low_rule = '0;
        for (int i = 7; i >= 0; i--) begin
            if (fail[i]) low_rule = 3'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SB_WAIT_FIRST: if (decode) state_d = SB_RUN;
            SB_RUN:        if (decode & pdp_op7_opcode.hlt) state_d = SB_HALTED;
            SB_HALTED:     state_d = SB_HALTED;
            default:       state_d = SB_WAIT_FIRST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= SB_WAIT_FIRST;
            prev_req   <= 1'b0;
            prev_stall <= 1'b0;
            fetch_pend <= 1'b0;
            err_sticky <= '0;
            err_pulse  <= 1'b0;
            err_rule   <= '0;
            chk_cnt    <= '0;
            fail_cnt   <= '0;
        end else begin
            state_q    <= state_d;
            prev_req   <= ifu_rd_req;
            prev_stall <= stall;
            fetch_pend <= fetch;
            err_sticky <= err_sticky | fail;
            err_pulse  <= |fail;
            err_rule   <= low_rule;
            if (decode && chk_cnt != '1) chk_cnt <= chk_cnt + CNT_ONE;
            if (decode && |(fail & DECODE_RULES) && fail_cnt != '1) begin
                fail_cnt <= fail_cnt + CNT_ONE;
            end
        end
    end

`ifdef IFD_SB_COV_EN
    logic [CNT_W-1:0] bins [NUM_BINS];
    logic             cov_hit;

    assign cov_hit = decode & ~empty & ~fail[RULE_MULTI] & ~fail[RULE_MISMATCH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_BINS; i++) begin
            if (reset) begin
                bins[i] <= '0;
            end else if (cov_hit && flags[i] && bins[i] != '1) begin
                bins[i] <= bins[i] + CNT_ONE;
            end
        end
    end

    always_comb begin
        cov_cnt = '0;
        for (int i = 0; i < NUM_BINS; i++) begin
            if (cov_sel == 5'(i)) cov_cnt = bins[i];
        end
    end
`else
    logic unused_cov;
    assign unused_cov = ^cov_sel;
    assign cov_cnt    = '0;
`endif

endmodule

// File: tb/tb_ifd_scoreboard.sv
// Self-checking bench for ifd_scoreboard: directed fetch/decode sequences, a
// queue-based reference model compared every cycle, plus literal spot checks.
module tb_ifd_scoreboard;
    import pdp8_pkg::*;

    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            ifu_rd_req = 1'b0;
    logic [11:0]     ifu_rd_addr = '0;
    logic [11:0]     ifu_rd_data = '0;
    logic [11:0]     base_addr = 12'o200;
    pdp_mem_opcode_s pdp_mem_opcode = '0;
    pdp_op7_opcode_s pdp_op7_opcode = '0;
    logic            stall = 1'b0;
    logic [11:0]     PC_value = '0;
    logic [4:0]      cov_sel = '0;
    logic [7:0]      err_sticky;
    logic            err_pulse;
    logic [2:0]      err_rule;
    logic [15:0]     chk_cnt, fail_cnt, cov_cnt;
    logic [1:0]      sb_state;

    int checks = 0;
    int failures = 0;
    logic cmp_en = 1'b0;

    ifd_scoreboard dut (
        .clk(clk), .reset(reset), .ifu_rd_req(ifu_rd_req), .ifu_rd_addr(ifu_rd_addr),
        .ifu_rd_data(ifu_rd_data), .base_addr(base_addr), .pdp_mem_opcode(pdp_mem_opcode),
        .pdp_op7_opcode(pdp_op7_opcode), .stall(stall), .PC_value(PC_value),
        .err_sticky(err_sticky), .err_pulse(err_pulse), .err_rule(err_rule),
        .chk_cnt(chk_cnt), .fail_cnt(fail_cnt), .cov_sel(cov_sel), .cov_cnt(cov_cnt),
        .sb_state(sb_state)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [11:0] op7_tbl [22] = '{12'o7000, 12'o7001, 12'o7004, 12'o7006, 12'o7010, 12'o7012,
                                  12'o7020, 12'o7040, 12'o7041, 12'o7100, 12'o7300, 12'o7200,
                                  12'o7402, 12'o7404, 12'o7410, 12'o7420, 12'o7430, 12'o7440,
                                  12'o7450, 12'o7500, 12'o7510, 12'o7600};

    logic [39:0] exp_q[$];
    int          m_bins [28];
    logic [7:0]  m_sticky = '0;
    logic        m_pulse = 1'b0;
    logic [2:0]  m_rule = '0;
    logic [15:0] m_chk = '0, m_fail = '0;
    int          m_phase = 0;   // 0 waiting for first decode, 1 running, 2 halted
    logic        m_prev_req = 1'b0, m_prev_stall = 1'b0, m_pend = 1'b0;

    function automatic logic [39:0] v_op7(input int i);
        logic [39:0] v;
        v = '0;
        v[21-i] = 1'b1;
        return v;
    endfunction

    function automatic logic [39:0] v_mem(input int k, input logic [11:0] a);
        logic [39:0] v;
        v = '0;
        v[39-k] = 1'b1;
        v[33:22] = a;
        return v;
    endfunction

    function automatic logic [39:0] model_predict(input logic [11:0] word);
        int opc;
        opc = int'(word[11:9]);
        if (opc <= 5) return v_mem(opc, {3'b000, word[8:0]});
        if (opc == 6) return '0;
        for (int i = 0; i < 22; i++) if (word == op7_tbl[i]) return v_op7(i);
        return v_op7(0);
    endfunction

    function automatic int bin_of(input logic [39:0] v);
        for (int i = 0; i < 22; i++) if (v[21-i]) return i;
        for (int k = 0; k < 6; k++) if (v[39-k]) return 22 + k;
        return 0;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    task automatic model_step();
        logic [39:0] obs, head;
        logic [7:0]  f;
        int          nf;
        logic        fe, de;
        if (reset) begin
            exp_q.delete();
            foreach (m_bins[i]) m_bins[i] = 0;
            m_sticky = '0; m_pulse = 1'b0; m_rule = '0; m_chk = '0; m_fail = '0;
            m_phase = 0; m_prev_req = 1'b0; m_prev_stall = 1'b0; m_pend = 1'b0;
            return;
        end
        obs = {pdp_mem_opcode, pdp_op7_opcode};
        nf  = $countones({obs[39:34], obs[21:0]});
        fe  = ifu_rd_req && !m_prev_req;
        de  = (nf > 0) && stall && !m_prev_stall;
        f   = '0;
        if (de) begin
            m_chk = sat_inc(m_chk);
            if (nf > 1) f[0] = 1'b1;
            if (m_phase == 0 && base_addr != 12'o200) f[3] = 1'b1;
            if (exp_q.size() == 0) begin
                f[6] = 1'b1;
            end else begin
                head = exp_q.pop_front();
                if (head != obs) f[1] = 1'b1;
                else if (nf == 1) m_bins[bin_of(obs)]++;
            end
        end
        if (fe) begin
            if (obs != '0) f[2] = 1'b1;
            if (m_phase == 1 && ifu_rd_addr != PC_value) f[4] = 1'b1;
            if (m_phase == 2) f[7] = 1'b1;
        end
        if (m_pend) begin
            if (exp_q.size() >= DEPTH) f[5] = 1'b1;
            else exp_q.push_back(model_predict(ifu_rd_data));
        end
        if (de && (f[0] || f[1] || f[3] || f[6])) m_fail = sat_inc(m_fail);
        if (de && m_phase == 0) m_phase = 1;
        else if (de && m_phase == 1 && obs[9]) m_phase = 2;
        m_sticky |= f;
        m_pulse = (f != '0);
        m_rule = '0;
        for (int i = 7; i >= 0; i--) if (f[i]) m_rule = 3'(i);
        m_pend = fe;
        m_prev_req = ifu_rd_req;
        m_prev_stall = stall;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- scoreboard compare ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        logic [15:0] exp_cov;
        @(negedge clk);
        if (cmp_en) begin
            exp_cov = '0;
`ifdef IFD_SB_COV_EN
            if (cov_sel < 5'd28) exp_cov = 16'(m_bins[cov_sel]);
`endif
            check("err_sticky", 64'(err_sticky), 64'(m_sticky));
            check("err_pulse", 64'(err_pulse), 64'(m_pulse));
            check("err_rule", 64'(err_rule), 64'(m_rule));
            check("chk_cnt", 64'(chk_cnt), 64'(m_chk));
            check("fail_cnt", 64'(fail_cnt), 64'(m_fail));
            check("cov_cnt", 64'(cov_cnt), 64'(exp_cov));
            check("state", 64'(sb_state), 64'(m_phase));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic fetch(input logic [11:0] addr, input logic [11:0] pc, input logic [11:0] data);
        step();
        ifu_rd_req = 1'b1;
        ifu_rd_addr = addr;
        PC_value = pc;
        step();
        ifu_rd_req = 1'b0;
        ifu_rd_data = data;
        step();
        ifu_rd_data = '0;
    endtask

    task automatic drive_op(input logic [39:0] v);
        pdp_mem_opcode = pdp_mem_opcode_s'(v[39:22]);
        pdp_op7_opcode = pdp_op7_opcode_s'(v[21:0]);
    endtask

    // Outputs reflecting the decode are visible when this returns.
    task automatic decode(input logic [39:0] v);
        step();
        drive_op(v);
        stall = 1'b1;
        step();
        drive_op('0);
        stall = 1'b0;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        do_reset();
        cmp_en = 1'b1;
        check("reset_sticky", 64'(err_sticky), 64'h0);
        check("reset_chk", 64'(chk_cnt), 64'h0);

        // 1: TAD 'o205 fetched at 'o200 and decoded correctly
        fetch(12'o200, 12'o200, 12'o1205);
        decode(v_mem(1, 12'o205));
        check("t1_chk_cnt", 64'(chk_cnt), 64'd1);
        check("t1_sticky", 64'(err_sticky), 64'h0);
        check("t1_state", 64'(sb_state), 64'(SB_RUN));

        // 2: IAC fetched, decoder reports CMA
        fetch(12'o201, 12'o201, 12'o7001);
        decode(v_op7(7));
        check("t2_pulse", 64'(err_pulse), 64'd1);
        check("t2_rule", 64'(err_rule), 64'd1);
        check("t2_fail_cnt", 64'(fail_cnt), 64'd1);

        // 3: five fetches overflow a 4-deep queue; first four still match
        do_reset();
        for (int i = 0; i < 5; i++) fetch(12'(12'o200 + i), 12'o0, 12'(12'o1210 + i));
        check("t3_overflow", 64'(err_sticky), 64'h20);
        for (int i = 0; i < 4; i++) decode(v_mem(1, 12'(12'o210 + i)));
        check("t3_sticky", 64'(err_sticky), 64'h20);
        check("t3_chk_cnt", 64'(chk_cnt), 64'd4);
        check("t3_fail_cnt", 64'(fail_cnt), 64'd0);

        // 4: decode with empty queue
        do_reset();
        decode(v_mem(1, 12'o205));
        check("t4_sticky", 64'(err_sticky), 64'h40);
        check("t4_chk_cnt", 64'(chk_cnt), 64'd1);

        // 5: HLT then fetch while halted, then reset clears everything
        fetch(12'o200, 12'o200, 12'o7402);
        decode(v_op7(12));
        check("t5_halted", 64'(sb_state), 64'(SB_HALTED));
        fetch(12'o201, 12'o201, 12'o7000);
        check("t5_sticky", 64'(err_sticky), 64'hC0);
        do_reset();
        check("t5_rst_sticky", 64'(err_sticky), 64'h0);
        check("t5_rst_cnt", 64'({chk_cnt, fail_cnt}), 64'h0);
        check("t5_rst_state", 64'(sb_state), 64'(SB_WAIT_FIRST));

        // 7: wrong base, PC mismatch, opcodes at fetch edge, multi-bit decode
        base_addr = 12'o100;
        fetch(12'o200, 12'o200, 12'o1205);
        decode(v_mem(1, 12'o205));
        check("t7_start", 64'(err_sticky), 64'h08);
        base_addr = 12'o200;
        fetch(12'o201, 12'o300, 12'o7001);
        check("t7_pc", 64'(err_sticky), 64'h18);
        drive_op(v_op7(1));
        fetch(12'o202, 12'o202, 12'o7040);
        drive_op('0);
        check("t7_fetch_opc", 64'(err_sticky), 64'h1C);
        decode(v_op7(1) | v_op7(11));
        check("t7_multi_rule", 64'(err_rule), 64'd0);
        check("t7_sticky", 64'(err_sticky), 64'h1F);

        // 8: push and pop in the same cycle on a full queue
        do_reset();
        for (int i = 0; i < 4; i++) fetch(12'(12'o200 + i), 12'o0, 12'(12'o3100 + i));
        step();
        ifu_rd_req = 1'b1;
        ifu_rd_addr = 12'o204;
        step();
        ifu_rd_req = 1'b0;
        ifu_rd_data = 12'o3104;
        drive_op(v_mem(3, 12'o100));
        stall = 1'b1;
        step();
        ifu_rd_data = '0;
        drive_op('0);
        stall = 1'b0;
        check("t8_no_overflow", 64'(err_sticky), 64'h0);
        for (int i = 1; i < 5; i++) decode(v_mem(3, 12'(12'o100 + i)));
        check("t8_sticky", 64'(err_sticky), 64'h0);
        check("t8_chk_cnt", 64'(chk_cnt), 64'd5);

        // 6: coverage bins
        do_reset();
        for (int i = 0; i < 3; i++) begin
            fetch(12'(12'o200 + i), 12'(12'o200 + i), 12'o1205);
            decode(v_mem(1, 12'o205));
        end
        cov_sel = 5'd23;
        #1;
`ifdef IFD_SB_COV_EN
        check("t6_cov_tad", 64'(cov_cnt), 64'd3);
`else
        check("t6_cov_off", 64'(cov_cnt), 64'd0);
`endif
        cov_sel = 5'd30;
        #1;
        check("t6_cov_oob", 64'(cov_cnt), 64'd0);
        step();
        step();

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
